load_store_unit: RTL and testbench

Memory-stage adapter between the pipeline's MEM stage and the word-wide data memory. Translates RV32I loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) on byte addresses into word-indexed accesses. Sub-word stores use a two-cycle read-modify-write, because the data memory has only one whole-word write enable. Loads are byte-lane extracted and extended before writeback.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Adapter between the pipeline MEM stage and a word-wide data memory.
// Byte-addressed RV32I loads/stores (lb/lh/lw/lbu/lhu/sb/sh/sw) become
// word-indexed memory accesses. The memory has one whole-word write enable,
// so sb/sh are done as a read-modify-write: the IDLE cycle reads the word
// and merges the new lane, and the WRITE cycle writes the merged word back.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   mem_read         load request from MEM stage
//   mem_write        store request from MEM stage (wins over mem_read)
//   funct3           RV32I load/store funct3
//   adr              byte address (ALU result)
//   wdata            store data (rs2)
//   rdata            extended load result to writeback
//   stall            hold PC and IF/ID/EX/MEM registers this cycle
//   access_fault     sticky misaligned/unsupported-access flag
//   dm_write_enable  data memory write enable
//   dm_adr           word index to data memory
//   dm_din           word written to data memory
//   dm_dout          combinational read word from data memory at dm_adr
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int N = 32,
    parameter int M = 32   // funct3 decode assumes M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] adr,
    input  logic [M-1:0] wdata,
    output logic [M-1:0] rdata,
    output logic         stall,
    output logic         access_fault,
    output logic         dm_write_enable,
    output logic [N-1:0] dm_adr,
    output logic [M-1:0] dm_din,
    input  logic [M-1:0] dm_dout
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] adr_q;
    logic [M-1:0] merge_q;

    logic is_store;
    logic is_load;
    logic supported;
    logic aligned;
    logic legal;
    logic fault_set;

    // Byte/halfword lane extraction with sign or zero extension.
    function automatic logic [M-1:0] load_extend(input logic [M-1:0] word,
                                                 input logic [2:0]   f3,
                                                 input logic [1:0]   lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [M-1:0]       res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{(M-8){b[7]}}, b};
            3'b001:  res = {{(M-16){h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {{(M-8){1'b0}}, b};
            3'b101:  res = {{(M-16){1'b0}}, h};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the old word with the store data.
    function automatic logic [M-1:0] merge_store(input logic [M-1:0] old,
                                                 input logic [M-1:0] wd,
                                                 input logic [2:0]   f3,
                                                 input logic [1:0]   lane);
        logic [M-1:0] res;
        res = old;
        if (f3 == 3'b000)
            res[{lane, 3'b000} +: 8] = wd[7:0];
        else
            res[{lane[1], 4'b0000} +: 16] = wd[15:0];
        return res;
    endfunction

    // Request decode: a simultaneous read and write is handled as a store.
    always_comb begin
        is_store = mem_write;
        is_load  = mem_read & ~mem_write;
        if (is_store)
            supported = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            supported = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~adr[0];
            2'b10:   aligned = (adr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        legal = supported & aligned;
    end

    // Next state and outputs.
    always_comb begin
        state_next      = state;
        rdata           = '0;
        stall           = 1'b0;
        dm_write_enable = 1'b0;
        dm_adr          = {2'b00, adr[N-1:2]};
        dm_din          = wdata;
        fault_set       = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    if (!legal) begin
                        fault_set = 1'b1;
                    end else if (funct3 == 3'b010) begin
                        dm_write_enable = 1'b1;
                    end else begin
                        // Sub-word store: read now, write merged word next cycle.
                        stall      = 1'b1;
                        state_next = WRITE;
                    end
                end else if (is_load) begin
                    if (legal)
                        rdata = load_extend(dm_dout, funct3, adr[1:0]);
                    else
                        fault_set = 1'b1;
                end
            end
            WRITE: begin
                // MEM-stage inputs are ignored here; only the captured access is written.
                dm_adr          = adr_q;
                dm_din          = merge_q;
                dm_write_enable = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            adr_q        <= '0;
            merge_q      <= '0;
            access_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (fault_set)
                access_fault <= 1'b1;
            // stall is only raised on the read half of a sub-word store.
            if (stall) begin
                adr_q   <= dm_adr;
                merge_q <= merge_store(dm_dout, wdata, funct3, adr[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] adr, wdata;
    logic [31:0] rdata;
    logic        stall, access_fault, dm_write_enable;
    logic [31:0] dm_adr, dm_din, dm_dout;

    int n_checks = 0;
    int n_err    = 0;

    load_store_unit #(.N(32), .M(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .adr(adr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .access_fault(access_fault), .dm_write_enable(dm_write_enable),
        .dm_adr(dm_adr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT (16 words).
    logic [31:0] mem [16] = '{default: 32'h0};
    assign dm_dout = mem[dm_adr[3:0]];
    always @(posedge clk) if (dm_write_enable) mem[dm_adr[3:0]] <= dm_din;

    // Reference model state.
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic        fault_m = 1'b0;

    // Per-cycle expectations consumed by the compare process.
    logic        exp_valid = 1'b0;
    logic        chk_rd    = 1'b0;
    logic        exp_stall, exp_we, exp_fault;
    logic [31:0] exp_rdata, exp_wadr;
    logic [31:0] last_rdata;
    int          last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("we", 32'(dm_write_enable), 32'(exp_we));
            chk("fault", 32'(access_fault), 32'(exp_fault));
            if (chk_rd) chk("rdata", rdata, exp_rdata);
            if (exp_we) chk("wadr", dm_adr, exp_wadr);
        end
    end

    function automatic logic legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic supported;
        int   bytes;
        if (st) supported = (f3 <= 3'd2);
        else    supported = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        bytes = 1 << f3[1:0];
        return supported && ((a % bytes) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] v;
        v = word >> (8 * a[1:0]);
        if (f3[1:0] == 2'd0) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] mask;
        int          sh;
        if (f3 == 3'd2) return wd;
        sh   = 8 * a[1:0];
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic set_idle();
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; adr = 32'd0; wdata = 32'd0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        logic        ok;
        logic [31:0] nw;
        int          nst;
        ok = legal(wr, f3, a);
        mem_read = rd; mem_write = wr; funct3 = f3; adr = a; wdata = wd;
        exp_fault = fault_m;
        exp_stall = wr && ok && (f3 != 3'd2);
        exp_we    = wr && ok && (f3 == 3'd2);
        exp_wadr  = a >> 2;
        exp_rdata = (rd && !wr && ok) ? model_load(ref_mem[a[5:2]], f3, a) : 32'd0;
        chk_rd    = 1'b1;
        exp_valid = 1'b1;
        @(negedge clk);
        last_rdata = rdata;
        nst = int'(stall);
        @(posedge clk); #1;
        if ((rd || wr) && !ok) fault_m = 1'b1;
        if (wr && ok) begin
            nw = model_store(ref_mem[a[5:2]], wd, f3, a);
            if (f3 != 3'd2) begin
                // Second cycle: DUT must ignore whatever MEM presents now.
                mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
                adr = $urandom; wdata = $urandom;
                exp_stall = 1'b0; exp_we = 1'b1; exp_fault = fault_m; chk_rd = 1'b0;
                @(negedge clk);
                nst += int'(stall);
                @(posedge clk); #1;
            end
            ref_mem[a[5:2]] = nw;
            chk("memword", mem[a[5:2]], nw);
        end
        last_stall = nst;
        exp_valid  = 1'b0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we", 32'(dm_write_enable), 32'd0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // Directed sequence with hand-computed values.
        issue(0, 1, 3'd2, 32'd0, 32'h0000_000A);
        issue(1, 0, 3'd2, 32'd0, 32'd0);  chk("lit_lw0", last_rdata, 32'h0000_000A);
        issue(1, 0, 3'd4, 32'd0, 32'd0);  chk("lit_lbu0", last_rdata, 32'h0000_000A);
        issue(1, 0, 3'd0, 32'd1, 32'd0);  chk("lit_lb1", last_rdata, 32'h0000_0000);
        issue(0, 1, 3'd0, 32'd1, 32'h80);
        chk("lit_sb_stall", 32'(last_stall), 32'd1);
        chk("lit_sb_mem", mem[0], 32'h0000_800A);
        issue(1, 0, 3'd0, 32'd1, 32'd0);  chk("lit_lb1b", last_rdata, 32'hFFFF_FF80);
        issue(1, 0, 3'd4, 32'd1, 32'd0);  chk("lit_lbu1", last_rdata, 32'h0000_0080);
        issue(0, 1, 3'd1, 32'd2, 32'h1234_BEEF);
        chk("lit_sh_mem", mem[0], 32'hBEEF_800A);
        issue(1, 0, 3'd1, 32'd2, 32'd0);  chk("lit_lh2", last_rdata, 32'hFFFF_BEEF);
        issue(1, 0, 3'd5, 32'd2, 32'd0);  chk("lit_lhu2", last_rdata, 32'h0000_BEEF);
        issue(0, 1, 3'd2, 32'd8, 32'hDEAD_BEEF);
        chk("lit_sw_stall", 32'(last_stall), 32'd0);
        chk("lit_sw_mem", mem[2], 32'hDEAD_BEEF);
        issue(1, 0, 3'd2, 32'd8, 32'd0);  chk("lit_lw8", last_rdata, 32'hDEAD_BEEF);

        // Faulting accesses.
        issue(0, 1, 3'd2, 32'd6, 32'h1111_2222);
        chk("lit_misal_mem", mem[1], 32'h0000_0000);
        chk("lit_fault_set", 32'(access_fault), 32'd1);
        issue(1, 0, 3'd1, 32'd3, 32'd0);  chk("lit_lh3", last_rdata, 32'd0);
        issue(1, 0, 3'd2, 32'd8, 32'd0);  chk("lit_after_fault", last_rdata, 32'hDEAD_BEEF);
        chk("lit_fault_hold", 32'(access_fault), 32'd1);

        // Reset asserted in the WRITE cycle of an sb.
        mem_write = 1'b1; funct3 = 3'd0; adr = 32'd8; wdata = 32'h55;
        @(posedge clk); #1;
        chk("mid_we_before", 32'(dm_write_enable), 32'd1);
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_we", 32'(dm_write_enable), 32'd0);
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_fault", 32'(access_fault), 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        chk("mid_mem", mem[2], 32'hDEAD_BEEF);
        rst_n   = 1'b1;
        fault_m = 1'b0;
        issue(1, 0, 3'd2, 32'd8, 32'd0);  chk("lit_post_rst", last_rdata, 32'hDEAD_BEEF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic rd, wr;
            int   kind;
            kind = int'($urandom_range(0, 9));
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            issue(rd, wr, 3'($urandom), 32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 7) == 0) begin
                exp_valid = 1'b1; chk_rd = 1'b1; exp_stall = 1'b0; exp_we = 1'b0;
                exp_fault = fault_m; exp_rdata = 32'd0;
                @(posedge clk); #1;
                exp_valid = 1'b0;
            end
        end
        for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_mem[w]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
